// File: rtl/eth_tx_ctrl_gen.sv
// eth_tx_ctrl_gen: simpleEthernet TX frame sequencer.
// Drives state, symbol/byte position and strobes for the TX datapath and CRC.

module eth_tx_ctrl_gen #(
  parameter int DATA_W         = 2,
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD    = 46,
  parameter int MAX_PAYLOAD    = 1500,
  parameter int IFG_BYTES      = 12
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Eth_Pkt_Rdy,
  input  logic        Fifo_Empty,
  output logic        Fifo_Rd,
  output logic [3:0]  Tx_Ctrl_FSM_State,
  output logic        Tx_En,
  output logic        Crc_En,
  output logic        Pad_Active,
  output logic [1:0]  Sym_Idx,
  output logic [10:0] Field_Byte,
  output logic [10:0] Payload_Len,
  output logic        Tx_Done,
  output logic        Tx_Trunc
);

  localparam int S = 8 / DATA_W;
  localparam logic [1:0]  SYM_LAST = 2'(S - 1);
  localparam logic [10:0] MIN_L    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_L    = 11'(MAX_PAYLOAD);
  localparam logic [11:0] PRE_L    = 12'(PREAMBLE_BYTES);
  localparam logic [11:0] IFG_L    = 12'(IFG_BYTES);

  if (!(DATA_W == 2 || DATA_W == 4 || DATA_W == 8)) begin : g_bad_width
    $error("eth_tx_ctrl_gen: DATA_W must be 2, 4 or 8");
  end
  if (MIN_PAYLOAD < 0 || MIN_PAYLOAD > MAX_PAYLOAD ||
      MAX_PAYLOAD > 2047) begin : g_bad_payload
    $error("eth_tx_ctrl_gen: need MIN_PAYLOAD <= MAX_PAYLOAD <= 2047");
  end
  if (PREAMBLE_BYTES < 1 || IFG_BYTES < 1) begin : g_bad_field
    $error("eth_tx_ctrl_gen: PREAMBLE_BYTES and IFG_BYTES must be >= 1");
  end

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_SFD      = 4'd2,
    ST_DEST     = 4'd3,
    ST_SRC      = 4'd4,
    ST_LEN      = 4'd5,
    ST_DATA     = 4'd6,
    ST_PAD      = 4'd7,
    ST_FCS      = 4'd8,
    ST_IFG      = 4'd9
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  sym_idx;
  logic [10:0] field_byte;
  logic [10:0] payload_len;
  logic [10:0] len_inc;
  logic [11:0] field_len;
  logic        byte_end;
  logic        field_last;
  logic        rd_req;
  logic        done_req;
  logic        trunc_req;

  assign byte_end = (state != ST_IDLE) && (sym_idx == SYM_LAST);
  assign len_inc  = (payload_len == 11'h7ff) ? payload_len
                                              : payload_len + 11'd1;

  // PAD length is whatever the payload fell short of the minimum
  always_comb begin
    field_len = 12'd1;
    case (state)
      ST_PREAMBLE: field_len = PRE_L;
      ST_DEST:     field_len = 12'd6;
      ST_SRC:      field_len = 12'd6;
      ST_LEN:      field_len = 12'd2;
      ST_PAD:      field_len = {1'b0, MIN_L} - {1'b0, payload_len};
      ST_FCS:      field_len = 12'd4;
      ST_IFG:      field_len = IFG_L;
      default:     field_len = 12'd1;
    endcase
    field_last = byte_end && (({1'b0, field_byte} + 12'd1) == field_len);
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    done_req  = 1'b0;
    trunc_req = 1'b0;
    case (state)
      ST_IDLE:     if (Eth_Pkt_Rdy) state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: if (field_last) state_nxt = ST_SFD;
      ST_SFD:      if (field_last) state_nxt = ST_DEST;
      ST_DEST:     if (field_last) state_nxt = ST_SRC;
      ST_SRC:      if (field_last) state_nxt = ST_LEN;
      ST_LEN: begin
        if (field_last) begin
          if (!Fifo_Empty) begin
            rd_req    = 1'b1;
            state_nxt = ST_DATA;
          end else if (MIN_L != 11'd0) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = ST_FCS;
          end
        end
      end
      ST_DATA: begin
        if (byte_end) begin
          if (len_inc == MAX_L) begin
            trunc_req = 1'b1;
            state_nxt = ST_FCS;
          end else if (!Fifo_Empty) begin
            rd_req = 1'b1;
          end else if (len_inc < MIN_L) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = ST_FCS;
          end
        end
      end
      ST_PAD:      if (field_last) state_nxt = ST_FCS;
      ST_FCS: begin
        if (field_last) begin
          done_req  = 1'b1;
          state_nxt = ST_IFG;
        end
      end
      ST_IFG:      if (field_last) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Tx_Ctrl_FSM_State = state;
    Tx_En             = 1'b0;
    Crc_En            = 1'b0;
    Pad_Active        = 1'b0;
    case (state)
      ST_PREAMBLE, ST_SFD, ST_FCS: Tx_En = 1'b1;
      ST_DEST, ST_SRC, ST_LEN, ST_DATA: begin
        Tx_En  = 1'b1;
        Crc_En = 1'b1;
      end
      ST_PAD: begin
        Tx_En      = 1'b1;
        Crc_En     = 1'b1;
        Pad_Active = 1'b1;
      end
      default: ;
    endcase
    Fifo_Rd     = rd_req & ~Rst;
    Tx_Done     = done_req & ~Rst;
    Tx_Trunc    = trunc_req & ~Rst;
    Sym_Idx     = sym_idx;
    Field_Byte  = field_byte;
    Payload_Len = payload_len;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sym_idx     <= '0;
      field_byte  <= '0;
      payload_len <= '0;
    end else begin
      if (state_nxt != state) begin
        sym_idx    <= '0;
        field_byte <= '0;
      end else if (byte_end) begin
        sym_idx    <= '0;
        field_byte <= field_byte + 11'd1;
      end else if (state != ST_IDLE) begin
        sym_idx <= sym_idx + 2'd1;
      end
      if (state_nxt == ST_IDLE)
        payload_len <= '0;
      else if (state == ST_DATA && byte_end)
        payload_len <= len_inc;
    end
  end

endmodule

// File: tb/tb_eth_tx_ctrl_gen.sv
// tb_eth_tx_ctrl_gen: randomized frame checks of eth_tx_ctrl_gen
// against a per-field frame model (RMII with short MAX, and MII).

module tb_eth_tx_ctrl_gen;

  localparam int MIN_P = 46;
  localparam int PRE   = 7;
  localparam int IFG   = 12;
  localparam int MAX0  = 60;
  localparam int MAX1  = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        rdy[2];
  logic        empty[2];
  logic        rd[2];
  logic        txen[2];
  logic        crc[2];
  logic        pad[2];
  logic        done[2];
  logic        trunc[2];
  logic [3:0]  st[2];
  logic [1:0]  sym[2];
  logic [10:0] fb[2];
  logic [10:0] plen[2];

  int tests = 0;
  int fails = 0;
  int s_of[2];
  int max_of[2];
  int cnt[2];

  eth_tx_ctrl_gen #(
    .DATA_W(2), .PREAMBLE_BYTES(PRE), .MIN_PAYLOAD(MIN_P),
    .MAX_PAYLOAD(MAX0), .IFG_BYTES(IFG)
  ) u_rmii (
    .Clk(clk), .Rst(rst[0]), .Eth_Pkt_Rdy(rdy[0]),
    .Fifo_Empty(empty[0]), .Fifo_Rd(rd[0]),
    .Tx_Ctrl_FSM_State(st[0]), .Tx_En(txen[0]), .Crc_En(crc[0]),
    .Pad_Active(pad[0]), .Sym_Idx(sym[0]), .Field_Byte(fb[0]),
    .Payload_Len(plen[0]), .Tx_Done(done[0]), .Tx_Trunc(trunc[0])
  );

  eth_tx_ctrl_gen #(
    .DATA_W(4), .PREAMBLE_BYTES(PRE), .MIN_PAYLOAD(MIN_P),
    .MAX_PAYLOAD(MAX1), .IFG_BYTES(IFG)
  ) u_mii (
    .Clk(clk), .Rst(rst[1]), .Eth_Pkt_Rdy(rdy[1]),
    .Fifo_Empty(empty[1]), .Fifo_Rd(rd[1]),
    .Tx_Ctrl_FSM_State(st[1]), .Tx_En(txen[1]), .Crc_En(crc[1]),
    .Pad_Active(pad[1]), .Sym_Idx(sym[1]), .Field_Byte(fb[1]),
    .Payload_Len(plen[1]), .Tx_Done(done[1]), .Tx_Trunc(trunc[1])
  );

  typedef struct {
    logic [3:0] st;
    int         sym;
    int         fb;
    bit         done;
    bit         trunc;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int d, input string tag);
    chk({tag, "_state"}, 32'(st[d]), 32'd0);
    chk({tag, "_outs"},
        32'({txen[d], crc[d], pad[d], rd[d], done[d], trunc[d],
             sym[d], fb[d], plen[d]}), 32'd0);
  endtask

  task automatic push_field(input int s, input logic [3:0] state,
                            input int nb, input bit dn, input bit tr);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < s; k++) begin
        ent_t e;
        e.st    = state;
        e.sym   = k;
        e.fb    = b;
        e.done  = dn && (b == nb - 1) && (k == s - 1);
        e.trunc = tr && (b == nb - 1) && (k == s - 1);
        q.push_back(e);
      end
    end
  endtask

  // Starts in an IDLE cycle just after a rising edge; returns likewise.
  task automatic run_frame(input int d, input int n, input bit hold,
                           input int abort_fb);
    int s;
    int plen_e;
    int pad_e;
    bit tr;
    int mism;
    int en_c;
    int crc_c;
    int pad_c;
    int rd_c;
    int ifg_c;
    int bad_rd;
    int obs_plen;
    string tg;
    s        = s_of[d];
    tr       = (n >= max_of[d]);
    plen_e   = tr ? max_of[d] : n;
    pad_e    = (plen_e < MIN_P) ? MIN_P - plen_e : 0;
    mism     = 0;
    en_c     = 0;
    crc_c    = 0;
    pad_c    = 0;
    rd_c     = 0;
    ifg_c    = 0;
    bad_rd   = 0;
    obs_plen = -1;
    tg       = $sformatf("d%0d_n%0d", d, n);
    q.delete();
    push_field(s, 4'd1, PRE, 1'b0, 1'b0);
    push_field(s, 4'd2, 1, 1'b0, 1'b0);
    push_field(s, 4'd3, 6, 1'b0, 1'b0);
    push_field(s, 4'd4, 6, 1'b0, 1'b0);
    push_field(s, 4'd5, 2, 1'b0, 1'b0);
    if (plen_e > 0) push_field(s, 4'd6, plen_e, 1'b0, tr);
    if (pad_e > 0)  push_field(s, 4'd7, pad_e, 1'b0, 1'b0);
    push_field(s, 4'd8, 4, 1'b1, 1'b0);
    push_field(s, 4'd9, IFG, 1'b0, 1'b0);
    cnt[d]   = n;
    rdy[d]   = 1'b1;
    empty[d] = (cnt[d] == 0);
    #1;
    idle_check(d, {tg, "_idle"});
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rdy[d] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (q[i].sym == s - 1) empty[d] = (cnt[d] == 0);
      else                   empty[d] = 1'($urandom_range(0, 1));
      if (abort_fb >= 0 && q[i].st == 4'd6 && q[i].fb == abort_fb &&
          q[i].sym == 0)
        rst[d] = 1'b1;
      #1;
      if (st[d] !== q[i].st || sym[d] !== 2'(q[i].sym) ||
          fb[d] !== 11'(q[i].fb) || done[d] !== q[i].done ||
          trunc[d] !== q[i].trunc)
        mism++;
      en_c  += int'(txen[d]);
      crc_c += int'(crc[d]);
      pad_c += int'(pad[d]);
      if (st[d] == 4'd9) ifg_c++;
      if (rd[d] === 1'b1) begin
        rd_c++;
        if (empty[d] || q[i].sym != s - 1) bad_rd++;
        else cnt[d]--;
      end
      if (done[d] === 1'b1) obs_plen = int'(plen[d]);
      if (rst[d]) begin
        chk({tg, "_pre_abort_trace"}, mism, 0);
        @(posedge clk);
        #1;
        rdy[d] = 1'b0;
        #1;
        idle_check(d, {tg, "_after_rst"});
        rst[d] = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) rdy[d] = 1'b0;
    chk({tg, "_trace"}, mism, 0);
    chk({tg, "_tx_en_cycles"}, en_c, s * (PRE + 19 + plen_e + pad_e));
    chk({tg, "_crc_cycles"}, crc_c, s * (14 + plen_e + pad_e));
    chk({tg, "_pad_cycles"}, pad_c, s * pad_e);
    chk({tg, "_fifo_reads"}, rd_c, plen_e);
    chk({tg, "_bad_reads"}, bad_rd, 0);
    chk({tg, "_ifg_cycles"}, ifg_c, s * IFG);
    chk({tg, "_payload_len"}, obs_plen, plen_e);
    chk({tg, "_end_state"}, 32'(st[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_of   = '{4, 2};
    max_of = '{MAX0, MAX1};
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b1;
      rdy[d]   = 1'b0;
      empty[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    idle_check(0, "reset_rmii");
    idle_check(1, "reset_mii");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    idle_check(0, "post_reset_rmii");

    run_frame(0, 46, 1'b0, -1);
    run_frame(0, 10, 1'b0, -1);
    run_frame(0, 0, 1'b0, -1);
    run_frame(0, 100, 1'b0, -1);
    run_frame(0, 60, 1'b0, -1);
    run_frame(0, 59, 1'b0, -1);
    run_frame(0, 45, 1'b0, -1);
    run_frame(0, 47, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    idle_check(0, "idle_gap");
    run_frame(0, 80, 1'b0, 20);
    run_frame(0, 46, 1'b0, -1);
    for (int k = 0; k < 3; k++)
      run_frame(0, int'($urandom_range(0, 90)), 1'b0, -1);

    run_frame(1, 46, 1'b1, -1);
    run_frame(1, 46, 1'b1, -1);
    for (int k = 0; k < 2; k++)
      run_frame(1, int'($urandom_range(0, 90)), 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_tx_ctrl_gen.md
Name: eth_tx_ctrl_gen

Overview:
Parametrised next-generation transmit frame sequencer for the simpleEthernet TX path. It sequences preamble, SFD, MAC header, payload reads from the TX FIFO, zero padding to the minimum frame size, the 4-byte FCS and the inter-frame gap. It supports RMII (2 bit), MII (4 bit) or byte-wide PHY symbol widths. It drives only control and strobes; the existing TX datapath and CRC block consume them.

Parameters:
DATA_W, 2, PHY symbol width in bits; legal values 2, 4, 8; symbols per byte S = 8/DATA_W.
PREAMBLE_BYTES, 7, number of 0x55 preamble bytes before the SFD.
MIN_PAYLOAD, 46, minimum payload bytes; shortfall is zero-padded.
MAX_PAYLOAD, 1500, payload byte limit; the frame is truncated here.
IFG_BYTES, 12, inter-frame gap length in byte times.

Ports:
Clk  in  1  system clock (one PHY symbol per cycle)
Rst  in  1  reset, synchronous, active-high
Eth_Pkt_Rdy  in  1  frame available in the TX FIFO; sampled only in IDLE
Fifo_Empty  in  1  TX FIFO empty
Fifo_Rd  out  1  one-cycle FIFO read pulse; data is valid on the next cycle
Tx_Ctrl_FSM_State  out  4  current state: IDLE0 PREAMBLE1 SFD2 DEST_ADDR3 SRC_ADDR4 LEN_TYPE5 DATA6 PAD7 FCS8 IFG9
Tx_En  out  1  PHY transmit enable
Crc_En  out  1  CRC accumulate enable
Pad_Active  out  1  datapath drives 0x00 bytes
Sym_Idx  out  2  symbol index within the current byte, 0..S-1
Field_Byte  out  11  byte index within the current field
Payload_Len  out  11  payload bytes read so far in this frame
Tx_Done  out  1  one-cycle pulse when a frame completes FCS
Tx_Trunc  out  1  one-cycle pulse when a frame is cut at MAX_PAYLOAD

Behaviour:
- Reset: state IDLE; every output 0; internal counters 0. Rst in any state, including mid-frame, returns to IDLE the next cycle with Tx_En=0.
- Sym_Idx counts 0..S-1 and wraps. A byte ends on the cycle where Sym_Idx==S-1. Field_Byte increments at each byte end and clears at every state change.
- All state changes happen only at a byte end, except IDLE->PREAMBLE.
- Field lengths in bytes: PREAMBLE=PREAMBLE_BYTES, SFD=1, DEST_ADDR=6, SRC_ADDR=6, LEN_TYPE=2, FCS=4, IFG=IFG_BYTES. Each state therefore lasts N*S cycles.
- IDLE: Sym_Idx=0, Field_Byte=0, Payload_Len=0. If Eth_Pkt_Rdy=1, next cycle state=PREAMBLE and Tx_En=1 (registered together). IDLE lasts at least 1 cycle.
- Crc_En is 1 from DEST_ADDR entry through the last PAD/DATA byte. It is 0 in all other states, including FCS.
- Last byte end of LEN_TYPE:
  - Fifo_Empty=0 -> Fifo_Rd=1, state DATA.
  - Fifo_Empty=1 -> state PAD with zero payload.
- DATA, at each byte end: Payload_Len += 1 (saturates, 11-bit). Then, using the incremented length:
  - length == MAX_PAYLOAD -> state FCS, Tx_Trunc pulse, no read.
  - else Fifo_Empty=0 -> Fifo_Rd=1, stay in DATA.
  - else if length < MIN_PAYLOAD -> state PAD.
  - else -> state FCS.
- Fifo_Rd is never asserted outside these byte-end cycles. It is never asserted when Fifo_Empty=1.
- PAD: Pad_Active=1 for (MIN_PAYLOAD - Payload_Len) bytes, then state FCS. Payload_Len does not change in PAD.
- FCS: 4 bytes. At the last byte end: Tx_Done pulse, Tx_En=0, state IFG.
- IFG: Tx_En=0 for IFG_BYTES*S cycles, then IDLE. Eth_Pkt_Rdy is ignored during IFG.
- Eth_Pkt_Rdy is ignored in every state except IDLE.
- A Fifo_Empty change mid-byte has no effect; it is sampled only at byte ends.
- Illegal state encoding -> IDLE next cycle with Tx_En=0.
- MIN_PAYLOAD ≤ MAX_PAYLOAD ≤ 2047 is required; violation is flagged by an elaboration-time check.

Test Plan:
- RMII (DATA_W=2), 46-byte FIFO: Eth_Pkt_Rdy pulse -> PREAMBLE 28, SFD 4, DEST 24, SRC 24, LEN 8, DATA 184, no PAD, FCS 16 cycles. Tx_En high 288 cycles; Fifo_Rd pulses exactly 46; then IFG 48 cycles.
- RMII, 10-byte payload -> Payload_Len=10; PAD lasts 36 bytes = 144 cycles with Pad_Active=1; Tx_En high 288 cycles total; Crc_En drops at FCS entry.
- RMII, FIFO empty at LEN_TYPE end -> zero Fifo_Rd pulses; PAD lasts 46 bytes = 184 cycles; Tx_Done pulses once.
- MAX_PAYLOAD=60, 100-byte FIFO -> exactly 60 Fifo_Rd pulses; Tx_Trunc pulses at the 60th byte end; FCS follows directly.
- DATA_W=4, 46-byte payload -> Sym_Idx alternates 0,1; Tx_En high 144 cycles. Eth_Pkt_Rdy held high -> next PREAMBLE starts 1 cycle after the 24-cycle IFG.
- Rst asserted at DATA byte 20 -> next cycle state=0 and all outputs 0; a new Eth_Pkt_Rdy produces a full correct frame.
